bp_mem_port_arbiter: RTL and testbench

Round-robin arbiter that lets `num_req_p` coherence-engine memory ports share one `bp_mem` instance. Each requester presents a command channel (valid/yumi). The block grants one requester at a time to the single downstream command port. It records the granted requester ID in an in-order tag FIFO and uses that FIFO to steer each returning memory response to the requester that issued the command. It sits between `bp_me_top` memory-side outputs and the memory model, replacing the per-CCE `bp_mem` instances.

---
 rtl/bp_mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bp_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_port_arbiter.sv
// bp_mem_port_arbiter
// Round-robin arbiter that lets num_req_p memory ports share one downstream
// memory. Commands are granted one at a time. The granted requester ID is
// recorded in an in-order tag FIFO, and that FIFO steers each returning
// response back to the requester that issued the command.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_n_i         asynchronous active-low reset
//   req_cmd_i         flattened requester command payloads
//   req_cmd_v_i       requester command valid (one bit per requester)
//   req_cmd_yumi_o    command accepted, one-hot or zero
//   mem_cmd_o         granted command payload
//   mem_cmd_v_o       downstream command valid
//   mem_cmd_yumi_i    memory consumed the command
//   mem_resp_i        memory response payload (responses arrive in command order)
//   mem_resp_v_i      memory response valid
//   mem_resp_ready_o  arbiter can route the response this cycle
//   req_resp_o        response payload, broadcast to all requesters
//   req_resp_v_o      per-requester response valid, one-hot or zero
//   req_resp_ready_i  per-requester response ready
//   outstanding_o     tag FIFO occupancy
module bp_mem_port_arbiter #(
  parameter int unsigned num_req_p         = 2,
  parameter int unsigned cmd_width_p       = 8,
  parameter int unsigned resp_width_p      = 8,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [cmd_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_yumi_i,
  input  logic [resp_width_p-1:0]          mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_ready_o,
  output logic [resp_width_p-1:0]          req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [cnt_width_lp-1:0]          outstanding_o
);

  localparam int unsigned ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  typedef enum logic {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } state_e;

  state_e                 state_r, state_n;
  logic [lg_req_lp-1:0]   grant_r, grant_n;
  logic [lg_req_lp-1:0]   rr_ptr_r, rr_ptr_n;

  logic [lg_req_lp-1:0]   tag_mem_r [max_outstanding_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] count_r;

  logic                   fifo_empty, fifo_full;
  logic [lg_req_lp-1:0]   head;
  logic                   push, pop;
  logic                   cmd_v;
  logic [lg_req_lp-1:0]   cur_sel;
  logic [num_req_p-1:0]   yumi;

  logic                   any_v;
  logic [lg_req_lp-1:0]   rr_sel;
  logic [lg_req_lp:0]     scan_sum;

  function automatic logic [lg_req_lp-1:0] rr_inc(input logic [lg_req_lp-1:0] p);
    return (p == lg_req_lp'(num_req_p - 1)) ? '0 : p + lg_req_lp'(1);
  endfunction

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign fifo_empty = (count_r == '0);
  assign fifo_full  = (count_r == cnt_width_lp'(max_outstanding_p));
  assign head       = tag_mem_r[rd_ptr_r];

  // First valid requester scanning upward from rr_ptr_r, wrapping modulo num_req_p
  always_comb begin
    any_v    = 1'b0;
    rr_sel   = rr_ptr_r;
    scan_sum = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      scan_sum = {1'b0, rr_ptr_r} + (lg_req_lp+1)'(i);
      if (scan_sum >= (lg_req_lp+1)'(num_req_p))
        scan_sum = scan_sum - (lg_req_lp+1)'(num_req_p);
      if (!any_v && req_cmd_v_i[scan_sum[lg_req_lp-1:0]]) begin
        any_v  = 1'b1;
        rr_sel = scan_sum[lg_req_lp-1:0];
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_idle;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      grant_r  <= grant_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  // Arbiter next state and command-side outputs; lock only taken when FIFO has room
  always_comb begin
    state_n  = state_r;
    grant_n  = grant_r;
    rr_ptr_n = rr_ptr_r;
    cmd_v    = 1'b0;
    cur_sel  = grant_r;
    push     = 1'b0;
    yumi     = '0;
    case (state_r)
      e_idle: begin
        if (any_v && !fifo_full) begin
          cmd_v   = 1'b1;
          cur_sel = rr_sel;
          if (mem_cmd_yumi_i) begin
            push     = 1'b1;
            rr_ptr_n = rr_inc(rr_sel);
          end else begin
            state_n = e_locked;
            grant_n = rr_sel;
          end
        end
      end
      e_locked: begin
        cmd_v   = 1'b1;
        cur_sel = grant_r;
        if (mem_cmd_yumi_i) begin
          push     = 1'b1;
          rr_ptr_n = rr_inc(grant_r);
          state_n  = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
    if (push) yumi[cur_sel] = 1'b1;
  end

  // Outputs forced to their reset values while reset is asserted
  assign mem_cmd_v_o    = cmd_v & reset_n_i;
  assign req_cmd_yumi_o = yumi & {num_req_p{reset_n_i}};

  // Command payload mux
  always_comb begin
    mem_cmd_o = '0;
    for (int i = 0; i < int'(num_req_p); i++)
      if (lg_req_lp'(i) == cur_sel) mem_cmd_o = req_cmd_i[i*cmd_width_p +: cmd_width_p];
  end

  // Response steering from the FIFO head; empty FIFO stalls the response
  always_comb begin
    req_resp_v_o     = '0;
    mem_resp_ready_o = 1'b0;
    if (!fifo_empty) begin
      req_resp_v_o[head] = mem_resp_v_i;
      mem_resp_ready_o   = req_resp_ready_i[head];
    end
  end

  assign req_resp_o = mem_resp_i;
  assign pop        = mem_resp_v_i & mem_resp_ready_o;

  // Tag FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(max_outstanding_p); i++) tag_mem_r[i] <= '0;
    end else begin
      if (push) begin
        tag_mem_r[wr_ptr_r] <= cur_sel;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign outstanding_o = count_r;

endmodule

// File: tb/tb_bp_mem_port_arbiter.sv
// Self-checking bench for bp_mem_port_arbiter: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bp_mem_port_arbiter;

  localparam int N    = 2;
  localparam int CW   = 8;
  localparam int RW   = 8;
  localparam int MAXO = 4;
  localparam int OW   = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*CW-1:0] req_cmd;
  logic [N-1:0]    req_v;
  logic [N-1:0]    cmd_yumi;
  logic [CW-1:0]   mem_cmd;
  logic            mem_cmd_v;
  logic            mem_yumi;
  logic [RW-1:0]   mem_resp;
  logic            mem_resp_v;
  logic            mem_resp_ready;
  logic [RW-1:0]   req_resp;
  logic [N-1:0]    resp_v_o;
  logic [N-1:0]    resp_ready;
  logic [OW-1:0]   outstanding;

  always #5 clk = ~clk;

  bp_mem_port_arbiter #(
    .num_req_p(N), .cmd_width_p(CW), .resp_width_p(RW), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_cmd_i(req_cmd), .req_cmd_v_i(req_v), .req_cmd_yumi_o(cmd_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_yumi_i(mem_yumi),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_ready_o(mem_resp_ready),
    .req_resp_o(req_resp), .req_resp_v_o(resp_v_o), .req_resp_ready_i(resp_ready),
    .outstanding_o(outstanding)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock flag, granted id, priority pointer, queue of issued ids
  bit m_locked = 1'b0;
  int m_grant  = 0;
  int m_rr     = 0;
  int m_tags[$];

  function automatic void model_cmd(output bit v, output int s);
    v = 1'b0;
    s = 0;
    if (!reset_n) return;
    if (m_locked) begin
      v = 1'b1;
      s = m_grant;
    end else if (m_tags.size() < MAXO) begin
      for (int i = 0; i < N; i++) begin
        if (!v && req_v[(m_rr + i) % N]) begin
          v = 1'b1;
          s = (m_rr + i) % N;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin : model_upd
    bit v;
    int s;
    bit pop;
    if (!reset_n) begin
      m_locked = 1'b0;
      m_grant  = 0;
      m_rr     = 0;
      m_tags.delete();
    end else begin
      model_cmd(v, s);
      pop = mem_resp_v && (m_tags.size() > 0) && resp_ready[m_tags[0]];
      if (pop) void'(m_tags.pop_front());
      if (v) begin
        if (mem_yumi) begin
          m_tags.push_back(s);
          m_rr     = (s + 1) % N;
          m_locked = 1'b0;
        end else begin
          m_locked = 1'b1;
          m_grant  = s;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    bit v;
    int s;
    bit empty;
    int head;
    logic [N-1:0] ey;
    logic [N-1:0] erv;
    model_cmd(v, s);
    empty = (m_tags.size() == 0);
    head  = empty ? 0 : m_tags[0];
    ey    = '0;
    if (v && mem_yumi) ey[s] = 1'b1;
    erv   = '0;
    if (mem_resp_v && !empty) erv[head] = 1'b1;
    chk("m_mem_cmd_v", mem_cmd_v, v);
    if (v) chk("m_mem_cmd", mem_cmd, req_cmd[s*CW +: CW]);
    chk("m_cmd_yumi", cmd_yumi, ey);
    chk("m_resp_v", resp_v_o, erv);
    chk("m_resp_ready", mem_resp_ready, !empty && resp_ready[head]);
    chk("m_resp_data", req_resp, mem_resp);
    chk("m_outstanding", outstanding, m_tags.size());
    if (reset_n && m_locked) chk("protocol_hold_valid", req_v[m_grant], 1'b1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c0;
    int c1;
    logic [1:0] exp_sv [3];
    exp_sv = '{2'b10, 2'b01, 2'b10};
    req_cmd    = {8'hB1, 8'hA0};
    req_v      = '0;
    mem_yumi   = 1'b0;
    mem_resp   = '0;
    mem_resp_v = 1'b0;
    resp_ready = '0;
    cyc();

    // Reset: outputs at reset values even with activity on the inputs
    req_v = 2'b11; mem_yumi = 1'b1; mem_resp_v = 1'b1; resp_ready = 2'b11;
    settle();
    chk("rst_cmd_v", mem_cmd_v, 1'b0);
    chk("rst_yumi", cmd_yumi, 2'b00);
    chk("rst_out", outstanding, 0);
    chk("rst_resp_ready", mem_resp_ready, 1'b0);
    chk("rst_resp_v", resp_v_o, 2'b00);
    cyc();
    reset_n = 1'b1; req_v = '0; mem_yumi = 1'b0; mem_resp_v = 1'b0;
    cyc();

    // Round-robin fairness with concurrent responses
    req_v = 2'b11; mem_yumi = 1'b1; mem_resp_v = 1'b1; resp_ready = 2'b11;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      mem_resp = 8'(8'h10 + i);
      settle();
      if (i == 0) chk("rr_first", cmd_yumi, 2'b01);
      if (i == 1) chk("rr_second", cmd_yumi, 2'b10);
      c0 += int'(cmd_yumi[0]);
      c1 += int'(cmd_yumi[1]);
      cyc();
    end
    chk("rr_cnt0", c0, 4);
    chk("rr_cnt1", c1, 4);
    req_v = '0; mem_yumi = 1'b0;
    settle();
    chk("rr_out_tail", outstanding, 1);
    cyc();
    settle();
    chk("rr_out_drained", outstanding, 0);
    mem_resp_v = 1'b0;
    cyc();

    // Lock stability: requester 0 held while requester 1 waits
    req_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mem_yumi = (i == 3);
      settle();
      chk("lock_cmd", mem_cmd, 8'hA0);
      chk("lock_v", mem_cmd_v, 1'b1);
      chk("lock_yumi", cmd_yumi, (i == 3) ? 2'b01 : 2'b00);
      cyc();
    end
    req_v = 2'b10; mem_yumi = 1'b1;
    settle();
    chk("lock_next_cmd", mem_cmd, 8'hB1);
    chk("lock_next_yumi", cmd_yumi, 2'b10);
    cyc();
    req_v = '0; mem_yumi = 1'b0;
    settle();
    chk("lock_out", outstanding, 2);
    mem_resp_v = 1'b1; resp_ready = 2'b11;
    cyc();
    cyc();
    mem_resp_v = 1'b0;
    settle();
    chk("lock_out_drained", outstanding, 0);
    cyc();

    // Response steering: issue 1, 0, 1 then return three responses
    mem_yumi = 1'b1;
    req_v = 2'b10; cyc();
    req_v = 2'b01; cyc();
    req_v = 2'b10; cyc();
    req_v = '0; mem_yumi = 1'b0;
    settle();
    chk("steer_out", outstanding, 3);
    mem_resp_v = 1'b1; resp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      mem_resp = 8'(8'h50 + i);
      settle();
      chk("steer_v", resp_v_o, exp_sv[i]);
      chk("steer_data", req_resp, 8'(8'h50 + i));
      cyc();
    end
    mem_resp_v = 1'b0;
    settle();
    chk("steer_out_end", outstanding, 0);
    cyc();

    // Full FIFO blocks a fifth grant until one response pops
    req_v = 2'b01; mem_yumi = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    settle();
    chk("full_out", outstanding, 4);
    chk("full_cmd_v", mem_cmd_v, 1'b0);
    chk("full_yumi", cmd_yumi, 2'b00);
    cyc();
    mem_resp_v = 1'b1; resp_ready = 2'b11;
    settle();
    chk("full_pop_ready", mem_resp_ready, 1'b1);
    chk("full_cmd_v_pop", mem_cmd_v, 1'b0);
    cyc();
    mem_resp_v = 1'b0;
    settle();
    chk("full_resume_yumi", cmd_yumi, 2'b01);
    chk("full_resume_out", outstanding, 3);
    cyc();
    req_v = '0; mem_yumi = 1'b0;
    settle();
    chk("full_refill_out", outstanding, 4);
    mem_resp_v = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    mem_resp_v = 1'b0;
    settle();
    chk("full_drained", outstanding, 0);
    cyc();

    // Response backpressure on head tag 1
    req_v = 2'b10; mem_yumi = 1'b1;
    cyc();
    req_v = '0; mem_yumi = 1'b0; mem_resp_v = 1'b1; resp_ready = 2'b01; mem_resp = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_ready", mem_resp_ready, 1'b0);
      chk("bp_v", resp_v_o, 2'b10);
      chk("bp_out", outstanding, 1);
      cyc();
    end
    resp_ready = 2'b11;
    settle();
    chk("bp_ready_go", mem_resp_ready, 1'b1);
    cyc();
    mem_resp_v = 1'b0;
    settle();
    chk("bp_out_end", outstanding, 0);
    cyc();

    // Reset mid-lock with two outstanding tags
    req_v = 2'b10; mem_yumi = 1'b1; cyc();
    req_v = 2'b01; cyc();
    req_v = 2'b11; mem_yumi = 1'b0; cyc();
    settle();
    chk("rml_out", outstanding, 2);
    chk("rml_locked_cmd", mem_cmd, 8'hB1);
    reset_n = 1'b0; mem_yumi = 1'b1;
    #1;
    chk("rml_cmd_v", mem_cmd_v, 1'b0);
    chk("rml_yumi", cmd_yumi, 2'b00);
    chk("rml_out_clr", outstanding, 0);
    chk("rml_resp_ready", mem_resp_ready, 1'b0);
    cyc();
    reset_n = 1'b1; req_v = 2'b11; mem_yumi = 1'b1;
    settle();
    chk("rml_first_grant", cmd_yumi, 2'b01);
    cyc();
    req_v = '0; mem_yumi = 1'b0; mem_resp_v = 1'b1; resp_ready = 2'b11;
    cyc();
    mem_resp_v = 1'b0;
    settle();
    chk("rml_out_end", outstanding, 0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
